// File: rtl/nibble_table_pkg.sv
// Shared constants, FSM state type and length decode for the nibble table writer.
package nibble_table_pkg;

  localparam int DATA_W  = 4;
  localparam int ADDR_W  = 6;
  localparam int ENTRIES = 1 << ADDR_W;
  // The remaining-count register must be able to hold the full 64 entries.
  localparam int CNT_W   = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  // A length field of 0 stands for a full-table burst.
  function automatic logic [CNT_W-1:0] decode_len(input logic [ADDR_W-1:0] len);
    decode_len = (len == '0) ? CNT_W'(ENTRIES) : {1'b0, len};
  endfunction

endpackage

// File: rtl/nibble_table_writer_dec6to64.sv
// One-hot write-enable decoder: selects the entry at addr when wr_stb is high.
module Dec6to64
  import nibble_table_pkg::*;
(
  input  logic [ADDR_W-1:0]  addr,
  input  logic               wr_stb,
  output logic [ENTRIES-1:0] wr_en
);

  // Decode the pointer into a single enable, all zero when no write occurs.
  always_comb begin
    wr_en = '0;
    if (wr_stb) begin
      wr_en[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/nibble_table_writer.sv
// 64 x 4-bit table loaded by auto-incrementing, wrapping bursts over a
// valid/ready stream; all entries are presented in parallel on Table.
// Optional zero sweep (Clear port, CLEAR state) when TABLE_CLEAR_EN is defined.
//
// Handshake: a write happens on a rising edge where DinValid and DinReady are
// both high; DinReady is high only in LOAD, and DinValid may drop at any time
// to stall the burst indefinitely without losing the pointer or count.
module nibble_table_writer
  import nibble_table_pkg::*;
(
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Start,
  input  logic [ADDR_W-1:0]         StartAddr,
  input  logic [ADDR_W-1:0]         Len,
  input  logic [DATA_W-1:0]         Din,
  input  logic                      DinValid,
`ifdef TABLE_CLEAR_EN
  input  logic                      Clear,
`endif
  output logic                      DinReady,
  output logic                      Busy,
  output logic                      Done,
  output logic [DATA_W*ENTRIES-1:0] Table,
  output state_t                    DbgState
);

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      done_q, done_d;
  logic                      wr_stb;
  logic [DATA_W-1:0]         wr_data;
  logic [ENTRIES-1:0]        wr_en;
  logic [DATA_W*ENTRIES-1:0] table_q;

  Dec6to64 u_dec (
    .addr   (ptr_q),
    .wr_stb (wr_stb),
    .wr_en  (wr_en)
  );

  // Next-state, pointer/count update and write strobe generation.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    wr_stb  = 1'b0;
    wr_data = Din;
    case (state_q)
      IDLE: begin
`ifdef TABLE_CLEAR_EN
        // Clear takes priority; a simultaneous Start is dropped.
        if (Clear) begin
          state_d = CLEAR;
          ptr_d   = '0;
          cnt_d   = CNT_W'(ENTRIES);
        end else
`endif
        if (Start) begin
          state_d = LOAD;
          ptr_d   = StartAddr;
          cnt_d   = decode_len(Len);
        end
      end
      LOAD: begin
        if (DinValid) begin
          wr_stb = 1'b1;
          ptr_d  = ptr_q + 1'b1;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
`ifdef TABLE_CLEAR_EN
      CLEAR: begin
        wr_stb  = 1'b1;
        wr_data = '0;
        ptr_d   = ptr_q + 1'b1;
        cnt_d   = cnt_q - 1'b1;
        if (ptr_q == ADDR_W'(ENTRIES - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Control registers; Done is registered so it lands the cycle after the last write.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Table storage: only the decoded entry is written, all others hold.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      table_q <= '0;
    end else begin
      for (int k = 0; k < ENTRIES; k++) begin
        if (wr_en[k]) begin
          table_q[k*DATA_W +: DATA_W] <= wr_data;
        end
      end
    end
  end

  assign DinReady = (state_q == LOAD);
  assign Busy     = (state_q != IDLE);
  assign Done     = done_q;
  assign Table    = table_q;
  assign DbgState = state_q;

endmodule

// File: tb/tb_nibble_table_writer.sv
// Directed bench for nibble_table_writer; exercises the optional zero sweep
// when TABLE_CLEAR_EN is defined.
module tb_nibble_table_writer;
  import nibble_table_pkg::*;

  // ---------------- clock / reset ----------------
  logic                      Clk = 1'b0;
  logic                      Reset;
  logic                      Start;
  logic [ADDR_W-1:0]         StartAddr;
  logic [ADDR_W-1:0]         Len;
  logic [DATA_W-1:0]         Din;
  logic                      DinValid;
`ifdef TABLE_CLEAR_EN
  logic                      Clear;
`endif
  logic                      DinReady;
  logic                      Busy;
  logic                      Done;
  logic [DATA_W*ENTRIES-1:0] Table;
  state_t                    DbgState;

  always #5 Clk = ~Clk;

  nibble_table_writer dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .StartAddr (StartAddr),
    .Len       (Len),
    .Din       (Din),
    .DinValid  (DinValid),
`ifdef TABLE_CLEAR_EN
    .Clear     (Clear),
`endif
    .DinReady  (DinReady),
    .Busy      (Busy),
    .Done      (Done),
    .Table     (Table),
    .DbgState  (DbgState)
  );

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_tbl [ENTRIES];
  int n_checks = 0;
  int n_pass   = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] model_flat();
    logic [255:0] r;
    for (int k = 0; k < ENTRIES; k++) r[k*DATA_W +: DATA_W] = exp_tbl[k];
    return r;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < ENTRIES; k++) exp_tbl[k] = '0;
  endtask

  // Per-cycle monitor, sampled 2 ns after each rising edge.
  always begin
    @(posedge Clk);
    #2;
    if (!Reset) begin
      if (Busy) busy_cnt++;
      if (Done) done_cnt++;
    end
  end

  // ---------------- driver ----------------
  // Entered and left 1 ns/3 ns after a rising edge; data comes from exp_q.
  task automatic do_burst(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] l,
                          input int stall, input bit poke);
    int n;
    logic [ADDR_W-1:0] idx;
    n = (l == 0) ? 64 : int'(l);
    busy_cnt = 0;
    done_cnt = 0;
    Start = 1'b1; StartAddr = a; Len = l;
    @(posedge Clk); #1;
    Start = 1'b0;
    StartAddr = ADDR_W'($urandom_range(0, 63));
    Len = ADDR_W'($urandom_range(0, 63));
    check("start_busy", Busy, 1);
    check("start_ready", DinReady, 1);
    check("start_done_low", Done, 0);
    for (int i = 0; i < n; i++) begin
      Din = exp_q.pop_front();
      DinValid = 1'b1;
      idx = a + ADDR_W'(i);
      @(posedge Clk); #1;
      exp_tbl[idx] = Din;
      DinValid = 1'b0;
      Din = DATA_W'($urandom_range(0, 15));
      if (i == 0 && stall > 0) begin
        if (poke) begin
          Start = 1'b1; StartAddr = 6'd40; Len = 6'd1;
        end
        repeat (stall) begin @(posedge Clk); #1; end
        Start = 1'b0;
        check("stall_table", Table, model_flat());
        check("stall_busy", Busy, 1);
      end
    end
    check("end_busy", Busy, 0);
    check("end_ready", DinReady, 0);
    check("end_done", Done, 1);
    check("end_table", Table, model_flat());
    #2;
    check("busy_cycles", busy_cnt, n + stall);
    check("done_pulses", done_cnt, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic clr_ready_bad;
    logic clr_busy_bad;
    Reset = 1'b1; Start = 1'b0; StartAddr = '0; Len = '0; Din = '0; DinValid = 1'b0;
`ifdef TABLE_CLEAR_EN
    Clear = 1'b0;
`endif
    model_clear();
    repeat (2) @(posedge Clk);
    #1;
    check("rst_table", Table, 0);
    check("rst_busy", Busy, 0);
    check("rst_ready", DinReady, 0);
    check("rst_done", Done, 0);
    check("rst_state", DbgState, IDLE);
    Reset = 1'b0;

    // Burst 5..7 = A,B,C
    exp_q.push_back(4'hA); exp_q.push_back(4'hB); exp_q.push_back(4'hC);
    do_burst(6'd5, 6'd3, 0, 1'b0);

    // Wrap burst, started during the Done cycle of the previous one
    for (int k = 1; k <= 4; k++) exp_q.push_back(DATA_W'(k));
    do_burst(6'd62, 6'd4, 0, 1'b0);
    check("entry2_kept", Table[2*DATA_W +: DATA_W], exp_tbl[2]);
    check("entry63", Table[63*DATA_W +: DATA_W], 4'h2);

    // Full 64-entry burst via Len=0
    @(posedge Clk); #1;
    for (int k = 0; k < 64; k++) exp_q.push_back(DATA_W'(k % 16));
    do_burst(6'd0, 6'd0, 0, 1'b0);
    check("entry37", Table[37*DATA_W +: DATA_W], 4'h5);

    // Stalled burst with Start poked mid-burst
    @(posedge Clk); #1;
    exp_q.push_back(4'h5); exp_q.push_back(4'h6); exp_q.push_back(4'h7);
    do_burst(6'd20, 6'd3, 5, 1'b1);
    check("entry40_kept", Table[40*DATA_W +: DATA_W], 4'h8);
    @(posedge Clk); #1;
    check("stall_done_fall", Done, 0);
    check("stall_idle", DbgState, IDLE);

    // Reset after 2 of 4 writes
    Start = 1'b1; StartAddr = 6'd10; Len = 6'd4;
    @(posedge Clk); #1;
    Start = 1'b0; Din = 4'hD; DinValid = 1'b1;
    @(posedge Clk); #1;
    exp_tbl[10] = 4'hD;
    Din = 4'hE;
    @(posedge Clk); #1;
    exp_tbl[11] = 4'hE;
    DinValid = 1'b0;
    check("partial_table", Table, model_flat());
    #2;
    Reset = 1'b1;
    #1;
    model_clear();
    check("midrst_table", Table, 0);
    check("midrst_busy", Busy, 0);
    check("midrst_ready", DinReady, 0);
    check("midrst_state", DbgState, IDLE);
    @(posedge Clk); #1;
    Reset = 1'b0;
    exp_q.push_back(4'h9);
    do_burst(6'd33, 6'd1, 0, 1'b0);

`ifdef TABLE_CLEAR_EN
    // Fill with F, then Clear and Start together in the Done cycle
    @(posedge Clk); #1;
    for (int k = 0; k < 64; k++) exp_q.push_back(4'hF);
    do_burst(6'd0, 6'd0, 0, 1'b0);
    Clear = 1'b1; Start = 1'b1; StartAddr = 6'd7; Len = 6'd2;
    @(posedge Clk); #1;
    Clear = 1'b0; Start = 1'b0;
    check("clr_state", DbgState, CLEAR);
    check("clr_busy", Busy, 1);
    clr_ready_bad = 1'b0;
    clr_busy_bad  = 1'b0;
    if (DinReady) clr_ready_bad = 1'b1;
    repeat (63) begin
      @(posedge Clk); #1;
      if (DinReady) clr_ready_bad = 1'b1;
      if (!Busy)    clr_busy_bad  = 1'b1;
    end
    check("clr_ready_low", clr_ready_bad, 0);
    check("clr_busy_64", clr_busy_bad, 0);
    @(posedge Clk); #1;
    model_clear();
    check("clr_done", Done, 1);
    check("clr_end_busy", Busy, 0);
    check("clr_table", Table, model_flat());
    @(posedge Clk); #1;
    check("clr_done_fall", Done, 0);
`else
    @(posedge Clk); #1;
    check("final_done_fall", Done, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
